// File: rtl/farrow_phase_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : farrow_phase_ctrl_if
// Brief   : Sample-in / window-out valid-ready bundle of the Farrow phase controller
// Revision: 1.0
// ============================================================================
interface farrow_phase_ctrl_if #(
    parameter int BITS = 16,
    parameter int TAPS = 6
);
    logic                 s_valid;
    logic                 s_ready;
    logic [BITS-1:0]      s_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [TAPS*BITS-1:0] m_window;
    logic [BITS-1:0]      mu;

    // master: the controller itself; slave: sample source plus datapath
    modport master (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_window, mu
    );

    modport slave (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_window, mu
    );
endinterface
`default_nettype wire

// File: rtl/farrow_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : farrow_phase_ctrl
// Brief   : Flow-controlled sample window and fractional phase sequencer for Farrow
// Revision: 1.0
// ============================================================================
module farrow_phase_ctrl #(
    parameter int          BITS     = 16,
    parameter int          TAPS     = 6,
    parameter int          INT_BITS = 4,
    parameter int unsigned STEP     = 32'h0_8000
) (
    input  wire                 clk,
    input  wire                 rst_n,
    input  wire                 flush,
    farrow_phase_ctrl_if.master bus
);
    localparam int              c_w    = INT_BITS + BITS;
    localparam int              c_cw   = $clog2(TAPS + 1);
    localparam logic [c_w-1:0]  c_step = c_w'(STEP);

    if (TAPS < 2) begin : g_bad_taps
        $error("farrow_phase_ctrl: TAPS must be at least 2");
    end

    if ((STEP == 0) || (64'(STEP) > ((64'd1 << c_w) - (64'd1 << BITS)))) begin : g_bad_step
        $error("farrow_phase_ctrl: STEP out of range 0 < STEP <= 2^(INT_BITS+BITS)-2^BITS");
    end

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_EMIT    = 2'd1,
        ST_ADVANCE = 2'd2
    } state_t;

    state_t               r_state,    w_state_nxt;
    logic [c_w-1:0]       r_acc,      w_acc_nxt;
    logic [c_cw-1:0]      r_fill_cnt, w_fill_nxt;
    logic [INT_BITS-1:0]  r_pend,     w_pend_nxt;
    logic [TAPS*BITS-1:0] r_window,   w_window_nxt;
    logic [BITS-1:0]      r_mu,       w_mu_nxt;
    logic                 r_m_valid,  w_m_valid_nxt;

    logic                 w_s_ready;
    logic                 w_accept;
    logic [c_w-1:0]       w_sum;
    logic [TAPS*BITS-1:0] w_shifted;

    assign w_s_ready = ((r_state == ST_FILL) || (r_state == ST_ADVANCE)) && !flush;
    assign w_accept  = bus.s_valid && w_s_ready;
    // acc holds only a fraction between outputs, so this sum cannot wrap
    assign w_sum     = r_acc + c_step;
    assign w_shifted = {r_window[(TAPS-1)*BITS-1:0], bus.s_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FILL;
            r_acc      <= '0;
            r_fill_cnt <= '0;
            r_pend     <= '0;
            r_window   <= '0;
            r_mu       <= '0;
            r_m_valid  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_fill_cnt <= w_fill_nxt;
            r_pend     <= w_pend_nxt;
            r_window   <= w_window_nxt;
            r_mu       <= w_mu_nxt;
            r_m_valid  <= w_m_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_fill_nxt   = r_fill_cnt;
        w_pend_nxt   = r_pend;
        w_window_nxt = r_window;
        w_mu_nxt     = r_mu;

        if (flush) begin
            // mu is left alone: it only ever changes when a new output is issued
            w_state_nxt  = ST_FILL;
            w_acc_nxt    = '0;
            w_fill_nxt   = '0;
            w_pend_nxt   = '0;
            w_window_nxt = '0;
        end else begin
            unique case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        w_window_nxt = w_shifted;
                        w_fill_nxt   = r_fill_cnt + c_cw'(1);
                        if (r_fill_cnt == c_cw'(TAPS - 1)) begin
                            w_state_nxt = ST_EMIT;
                            w_mu_nxt    = r_acc[BITS-1:0];
                        end
                    end
                end
                ST_EMIT: begin
                    if (r_m_valid && bus.m_ready) begin
                        if (w_sum[c_w-1:BITS] == '0) begin
                            w_acc_nxt = w_sum;
                            w_mu_nxt  = w_sum[BITS-1:0];
                        end else begin
                            w_pend_nxt  = w_sum[c_w-1:BITS];
                            w_acc_nxt   = {{INT_BITS{1'b0}}, w_sum[BITS-1:0]};
                            w_state_nxt = ST_ADVANCE;
                        end
                    end
                end
                ST_ADVANCE: begin
                    if (w_accept) begin
                        w_window_nxt = w_shifted;
                        w_pend_nxt   = r_pend - INT_BITS'(1);
                        if (r_pend == INT_BITS'(1)) begin
                            w_state_nxt = ST_EMIT;
                            w_mu_nxt    = r_acc[BITS-1:0];
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_FILL;
                end
            endcase
        end

        w_m_valid_nxt = (w_state_nxt == ST_EMIT);
    end

    assign bus.s_ready  = w_s_ready;
    assign bus.m_valid  = r_m_valid;
    assign bus.m_window = r_window;
    assign bus.mu       = r_mu;
endmodule
`default_nettype wire

// File: tb/tb_farrow_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_farrow_phase_ctrl
// Brief   : Random-stimulus bench for three STEP settings against a sample-position model
// Revision: 1.0
// ============================================================================
module tb_farrow_phase_ctrl;
    localparam int BITS     = 16;
    localparam int TAPS     = 6;
    localparam int INT_BITS = 4;
    localparam int NDUT     = 3;
    // interpolate by 4, interpolate by 2, decimate by 2.5
    localparam logic [NDUT*32-1:0] c_steps = {32'h2_8000, 32'h0_8000, 32'h0_4000};

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 flush = 1'b0;
    logic [NDUT-1:0]      s_valid;
    logic [NDUT-1:0]      m_ready;
    logic [BITS-1:0]      s_data  [NDUT];
    logic [NDUT-1:0]      obs_sr;
    logic [NDUT-1:0]      obs_mv;
    logic [BITS-1:0]      obs_mu  [NDUT];
    logic [TAPS*BITS-1:0] obs_win [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    // model: count of accepted samples and absolute position of the next output
    longint          n_acc   [NDUT];
    longint          pos     [NDUT];
    logic [BITS-1:0] m_win   [NDUT][TAPS];
    logic [BITS-1:0] mu_hold [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        farrow_phase_ctrl_if #(.BITS(BITS), .TAPS(TAPS)) bus ();

        farrow_phase_ctrl #(
            .BITS    (BITS),
            .TAPS    (TAPS),
            .INT_BITS(INT_BITS),
            .STEP    (c_steps[g*32 +: 32])
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .flush(flush),
            .bus  (bus)
        );

        assign bus.s_valid = s_valid[g];
        assign bus.s_data  = s_data[g];
        assign bus.m_ready = m_ready[g];
        assign obs_sr[g]   = bus.s_ready;
        assign obs_mv[g]   = bus.m_valid;
        assign obs_mu[g]   = bus.mu;
        assign obs_win[g]  = bus.m_window;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_avail(int i);
        return n_acc[i] == (longint'(TAPS) + (pos[i] >> BITS));
    endfunction

    task automatic model_clear(int i, bit clr_mu);
        n_acc[i] = 0;
        pos[i]   = 0;
        for (int k = 0; k < TAPS; k++) m_win[i][k] = '0;
        if (clr_mu) mu_hold[i] = '0;
    endtask

    task automatic model_step(int i);
        if (flush) begin
            model_clear(i, 1'b0);
        end else if (!model_avail(i)) begin
            if (s_valid[i]) begin
                for (int k = TAPS - 1; k > 0; k--) m_win[i][k] = m_win[i][k-1];
                m_win[i][0] = s_data[i];
                n_acc[i]++;
            end
        end else if (m_ready[i]) begin
            pos[i] += longint'(c_steps[i*32 +: 32]);
        end
        if (model_avail(i)) mu_hold[i] = pos[i][BITS-1:0];
    endtask

    task automatic check_outputs();
        for (int i = 0; i < NDUT; i++) begin
            logic [TAPS*BITS-1:0] ew;
            for (int k = 0; k < TAPS; k++) ew[k*BITS +: BITS] = m_win[i][k];
            check_eq($sformatf("m_valid[%0d]", i), 128'(obs_mv[i]), 128'(model_avail(i)));
            check_eq($sformatf("mu[%0d]", i), 128'(obs_mu[i]), 128'(mu_hold[i]));
            check_eq($sformatf("m_window[%0d]", i), 128'(obs_win[i]), 128'(ew));
        end
    endtask

    // entered just after a falling edge; leaves just after the next falling edge
    task automatic cycle(int pv, int pr, int pf);
        flush = ($urandom_range(99) < pf);
        for (int i = 0; i < NDUT; i++) begin
            s_valid[i] = ($urandom_range(99) < pv);
            m_ready[i] = ($urandom_range(99) < pr);
            s_data[i]  = BITS'($urandom);
        end
        #1;
        for (int i = 0; i < NDUT; i++)
            check_eq($sformatf("s_ready[%0d]", i), 128'(obs_sr[i]),
                     128'(!model_avail(i) && !flush));
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) model_step(i);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < NDUT; i++) model_clear(i, 1'b1);
        #1;
        check_outputs();
        flush = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            s_valid[i] = 1'b1;
            m_ready[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            s_valid[i] = 1'b0;
            m_ready[i] = 1'b0;
            s_data[i]  = '0;
            model_clear(i, 1'b1);
        end
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        repeat (40)  cycle(100, 100, 0);
        repeat (20)  cycle(100, 0, 0);
        repeat (300) cycle(60, 60, 0);
        repeat (200) cycle(90, 10, 0);
        repeat (200) cycle(30, 90, 0);
        repeat (300) cycle(70, 70, 4);
        pulse_reset();
        repeat (30)  cycle(100, 100, 0);
        repeat (300) cycle(80, 80, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
